instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have port instr_in, input, 32 bits, the fetched instruction word.
REQ-004 The block SHALL have port pc_in, input, 32 bits, the PC of instr_in.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning instr_in/pc_in are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the stage accepts input this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit, meaning discard the held entry and any entry offered this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning the decoded entry is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the entry this cycle.
REQ-010 The block SHALL have ports addu, subu, ori, lw, sw, beq, lui, jal, jr, nop, illegal, each output, 1 bit, registered one-hot instruction class.
REQ-011 The block SHALL have ports rs, rt, rd, each output, 5 bits; imm16, output, 16 bits; instr_out and pc_out, each output, 32 bits; all are registered fields of the held entry.

Function
REQ-012 The block SHALL drive in_ready = !flush & (!out_valid | out_ready), combinationally.
REQ-013 The block SHALL capture instr_in/pc_in on a rising edge where in_valid & in_ready, giving a latency of 1 cycle to out_valid.
REQ-014 The block SHALL hold every output stable while out_valid & !out_ready (back-pressure).
REQ-015 The block SHALL clear out_valid on the edge where the entry is consumed (out_valid & out_ready) and no new capture occurs.
REQ-016 The block SHALL support simultaneous consume and capture in one cycle, sustaining 1 entry/cycle with no bubble.
REQ-017 The block SHALL clear out_valid on the next edge when flush=1, regardless of out_ready or in_valid; flush has priority over capture and hold.
REQ-018 The block SHALL classify opcode 000000 as addu for funct 100001, subu for 100011 and jr for 001000.
REQ-019 The block SHALL classify opcode 001101 as ori, 100011 as lw, 101011 as sw, 000100 as beq, 001111 as lui and 000011 as jal.
REQ-020 The block SHALL classify instr 0x00000000 as nop, and every other encoding as illegal.
REQ-021 The block SHALL raise exactly one class output when out_valid=1, and drive all class outputs to 0 when out_valid=0.
REQ-022 The block SHALL take fields as rs=[25:21], rt=[20:16], rd=[15:11] and imm16=[15:0], with no extension performed here.
REQ-023 The block SHALL register the class outputs; it SHALL NOT decode them combinationally from the held word on the output side.

Reset
REQ-024 The block SHALL, on reset assertion, immediately force out_valid=0, all class outputs=0 and instr_out/pc_out/rs/rt/rd/imm16=0, independent of clk.
REQ-025 The block SHALL discard an entry held when reset asserts mid-operation, with no capture while reset=1.
REQ-026 The block SHALL present in_ready=1 on the first cycle after reset deasserts, provided flush=0.

Configuration
REQ-027 The block SHALL, when macro DECODE_ILLEGAL_CNT_EN is defined, add output illegal_cnt (8 bits), which increments once per consumed entry with illegal=1, saturates at 0xFF, is unaffected by flushed entries and resets to 0.
REQ-028 The block SHALL, when DECODE_ILLEGAL_CNT_EN is undefined, have no illegal_cnt port or counter logic, with all other behaviour identical.

Verification
REQ-029 The bench SHALL check: instr_in=0x34081234, in_valid=1, out_ready=1 -> next cycle out_valid=1, ori=1, rs=0, rt=8, imm16=0x1234, all other classes 0.
REQ-030 The bench SHALL check: back-to-back 0x01095021 then 0x03E00008 -> addu with rd=10, then jr with rs=31, on consecutive cycles with in_ready held 1.
REQ-031 The bench SHALL check: capture 0x8C000004 (lw) with out_ready=0 for 3 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> consumed, and the next input is accepted that cycle.
REQ-032 The bench SHALL check: flush=1 with out_valid=1 and in_valid=1 -> in_ready=0, and the next cycle out_valid=0 with all classes 0.
REQ-033 The bench SHALL check: instr 0xFC000000 -> illegal=1; instr 0x00000000 -> nop=1; with DECODE_ILLEGAL_CNT_EN, 300 consumed illegal entries -> illegal_cnt=0xFF.
REQ-034 The bench SHALL check: reset asserted mid-cycle while out_valid=1 -> out_valid=0 before the next clk edge.

Source files
------------

// File: rtl/instr_decode_if.sv
// Handshake and decoded-entry bundle for instr_decode_stage.
// illegal_cnt exists only when DECODE_ILLEGAL_CNT_EN is defined.
interface instr_decode_if;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        addu;
   logic        subu;
   logic        ori;
   logic        lw;
   logic        sw;
   logic        beq;
   logic        lui;
   logic        jal;
   logic        jr;
   logic        nop;
   logic        illegal;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
`ifdef DECODE_ILLEGAL_CNT_EN
   logic [7:0]  illegal_cnt;
`endif

   modport master (
`ifdef DECODE_ILLEGAL_CNT_EN
      input  illegal_cnt,
`endif
      output instr_in, pc_in, in_valid, flush, out_ready,
      input  in_ready, out_valid,
      input  addu, subu, ori, lw, sw, beq, lui, jal, jr, nop, illegal,
      input  rs, rt, rd, imm16, instr_out, pc_out
   );

   modport slave (
`ifdef DECODE_ILLEGAL_CNT_EN
      output illegal_cnt,
`endif
      input  instr_in, pc_in, in_valid, flush, out_ready,
      output in_ready, out_valid,
      output addu, subu, ori, lw, sw, beq, lui, jal, jr, nop, illegal,
      output rs, rt, rd, imm16, instr_out, pc_out
   );
endinterface

// File: rtl/instr_decode_stage.sv
// Single-entry decode pipeline register with valid/ready handshake and registered one-hot class.
// Optional saturating illegal-instruction counter: define DECODE_ILLEGAL_CNT_EN.
module instr_decode_stage (
   input logic           clk,
   input logic           reset,
   instr_decode_if.slave bus
);

   typedef struct packed {
      logic addu;
      logic subu;
      logic ori;
      logic lw;
      logic sw;
      logic beq;
      logic lui;
      logic jal;
      logic jr;
      logic nop;
      logic illegal;
   } cls_t;

   localparam logic [5:0] OpSpecial = 6'h00;
   localparam logic [5:0] OpOri     = 6'h0d;
   localparam logic [5:0] OpLw      = 6'h23;
   localparam logic [5:0] OpSw      = 6'h2b;
   localparam logic [5:0] OpBeq     = 6'h04;
   localparam logic [5:0] OpLui     = 6'h0f;
   localparam logic [5:0] OpJal     = 6'h03;
   localparam logic [5:0] FnAddu    = 6'h21;
   localparam logic [5:0] FnSubu    = 6'h23;
   localparam logic [5:0] FnJr      = 6'h08;

   // All-zero word is nop; the remaining special-opcode functs fall to illegal.
   function automatic cls_t decode(input logic [5:0] op, input logic [5:0] fn,
                                   input logic is_zero);
      cls_t c;
      c = '0;
      if (is_zero) begin
         c.nop = 1'b1;
      end else begin
         case (op)
            OpSpecial: begin
               case (fn)
                  FnAddu:  c.addu    = 1'b1;
                  FnSubu:  c.subu    = 1'b1;
                  FnJr:    c.jr      = 1'b1;
                  default: c.illegal = 1'b1;
               endcase
            end
            OpOri:   c.ori     = 1'b1;
            OpLw:    c.lw      = 1'b1;
            OpSw:    c.sw      = 1'b1;
            OpBeq:   c.beq     = 1'b1;
            OpLui:   c.lui     = 1'b1;
            OpJal:   c.jal     = 1'b1;
            default: c.illegal = 1'b1;
         endcase
      end
      return c;
   endfunction

   logic        out_valid_q, out_valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   cls_t        class_q, class_d;
   logic        in_ready;
   logic        capture;
   logic        consume;

   assign in_ready = ~bus.flush & (~out_valid_q | bus.out_ready);
   assign capture  = bus.in_valid & in_ready;
   assign consume  = out_valid_q & bus.out_ready;

   // Flush beats capture beats consume; class is cleared whenever the entry goes invalid.
   always_comb begin
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      class_d     = class_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
         class_d     = '0;
      end else if (capture) begin
         out_valid_d = 1'b1;
         instr_d     = bus.instr_in;
         pc_d        = bus.pc_in;
         class_d     = decode(bus.instr_in[31:26], bus.instr_in[5:0], bus.instr_in == 32'h0);
      end else if (consume) begin
         out_valid_d = 1'b0;
         class_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         pc_q        <= '0;
         class_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         class_q     <= class_d;
      end
   end

`ifdef DECODE_ILLEGAL_CNT_EN
   logic [7:0] illegal_cnt_q, illegal_cnt_d;

   // A flushed entry never counts, even if the consumer happened to be ready.
   always_comb begin
      illegal_cnt_d = illegal_cnt_q;
      if (consume && !bus.flush && class_q.illegal && (illegal_cnt_q != 8'hff)) begin
         illegal_cnt_d = illegal_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         illegal_cnt_q <= '0;
      end else begin
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign bus.illegal_cnt = illegal_cnt_q;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.instr_out = instr_q;
   assign bus.pc_out    = pc_q;
   assign bus.rs        = instr_q[25:21];
   assign bus.rt        = instr_q[20:16];
   assign bus.rd        = instr_q[15:11];
   assign bus.imm16     = instr_q[15:0];
   assign bus.addu      = class_q.addu;
   assign bus.subu      = class_q.subu;
   assign bus.ori       = class_q.ori;
   assign bus.lw        = class_q.lw;
   assign bus.sw        = class_q.sw;
   assign bus.beq       = class_q.beq;
   assign bus.lui       = class_q.lui;
   assign bus.jal       = class_q.jal;
   assign bus.jr        = class_q.jr;
   assign bus.nop       = class_q.nop;
   assign bus.illegal   = class_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed scenarios plus randomized handshake traffic
// checked against a queue-based reference model. Counter checks need DECODE_ILLEGAL_CNT_EN.
module tb_instr_decode_stage;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_decode_if dif ();

   instr_decode_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   // Class vector order: addu subu ori lw sw beq lui jal jr nop illegal
   localparam logic [10:0] CAddu = 11'b100_0000_0000;
   localparam logic [10:0] CSubu = 11'b010_0000_0000;
   localparam logic [10:0] COri  = 11'b001_0000_0000;
   localparam logic [10:0] CLw   = 11'b000_1000_0000;
   localparam logic [10:0] CSw   = 11'b000_0100_0000;
   localparam logic [10:0] CBeq  = 11'b000_0010_0000;
   localparam logic [10:0] CLui  = 11'b000_0001_0000;
   localparam logic [10:0] CJal  = 11'b000_0000_1000;
   localparam logic [10:0] CJr   = 11'b000_0000_0100;
   localparam logic [10:0] CNop  = 11'b000_0000_0010;
   localparam logic [10:0] CIll  = 11'b000_0000_0001;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t exp_q[$];
   int     tests  = 0;
   int     fails  = 0;
   logic   mon_en = 1'b0;

   logic [10:0] dut_cls;
   assign dut_cls = {dif.addu, dif.subu, dif.ori, dif.lw, dif.sw, dif.beq, dif.lui, dif.jal,
                     dif.jr, dif.nop, dif.illegal};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] exp_class(input logic [31:0] w);
      if (w == 32'h0) return CNop;
      case (w[31:26])
         6'd0: begin
            if (w[5:0] == 6'h21) return CAddu;
            if (w[5:0] == 6'h23) return CSubu;
            if (w[5:0] == 6'h08) return CJr;
            return CIll;
         end
         6'h0d:   return COri;
         6'h23:   return CLw;
         6'h2b:   return CSw;
         6'h04:   return CBeq;
         6'h0f:   return CLui;
         6'h03:   return CJal;
         default: return CIll;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [5:0]  ops [7];
      logic [5:0]  fns [4];
      ops = '{6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h03};
      fns = '{6'h21, 6'h23, 6'h08, 6'h2a};
      w = $urandom();
      case ($urandom_range(0, 9))
         0:       w = 32'h0;
         1, 2: begin
            w[31:26] = 6'h00;
            w[5:0]   = fns[$urandom_range(0, 3)];
         end
         3, 4, 5, 6, 7: w[31:26] = ops[$urandom_range(0, 6)];
         default: ;
      endcase
      return w;
   endfunction

   // Reference model: the stage holds at most one entry.
   always @(posedge clk or posedge reset) begin
      bit rdy;
      entry_t e;
      if (reset) begin
         exp_q.delete();
      end else begin
         rdy = !dif.flush && (exp_q.size() == 0 || dif.out_ready);
         if (dif.flush) begin
            exp_q.delete();
         end else begin
            if (exp_q.size() != 0 && dif.out_ready) void'(exp_q.pop_front());
            if (dif.in_valid && rdy) begin
               e.instr = dif.instr_in;
               e.pc    = dif.pc_in;
               exp_q.push_back(e);
            end
         end
      end
   end

   // Monitor on the inactive edge.
   always @(negedge clk) begin
      entry_t e;
      if (mon_en && !reset) begin
         chk("mon_in_ready", {31'b0, dif.in_ready},
             {31'b0, !dif.flush && (exp_q.size() == 0 || dif.out_ready)});
         chk("mon_out_valid", {31'b0, dif.out_valid}, {31'b0, exp_q.size() != 0});
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("mon_class", {21'b0, dut_cls}, {21'b0, exp_class(e.instr)});
            chk("mon_instr_out", dif.instr_out, e.instr);
            chk("mon_pc_out", dif.pc_out, e.pc);
            chk("mon_rs", {27'b0, dif.rs}, {27'b0, e.instr[25:21]});
            chk("mon_rt", {27'b0, dif.rt}, {27'b0, e.instr[20:16]});
            chk("mon_rd", {27'b0, dif.rd}, {27'b0, e.instr[15:11]});
            chk("mon_imm16", {16'b0, dif.imm16}, {16'b0, e.instr[15:0]});
         end else begin
            chk("mon_class_idle", {21'b0, dut_cls}, 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      dif.instr_in  = '0;
      dif.pc_in     = '0;
      dif.in_valid  = 1'b0;
      dif.flush     = 1'b0;
      dif.out_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, dif.out_valid}, 32'h0);
      chk("rst_class", {21'b0, dut_cls}, 32'h0);
      chk("rst_instr_out", dif.instr_out, 32'h0);
      chk("rst_pc_out", dif.pc_out, 32'h0);
      chk("rst_fields", {dif.rs, dif.rt, dif.rd, dif.imm16}, 32'h0);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      tick();
      chk("in_ready_after_reset", {31'b0, dif.in_ready}, 32'h1);

      // ori decode
      dif.instr_in  = 32'h3408_1234;
      dif.pc_in     = 32'h0000_0100;
      dif.in_valid  = 1'b1;
      dif.out_ready = 1'b1;
      tick();
      dif.in_valid = 1'b0;
      chk("ori_valid", {31'b0, dif.out_valid}, 32'h1);
      chk("ori_class", {21'b0, dut_cls}, {21'b0, COri});
      chk("ori_rs", {27'b0, dif.rs}, 32'd0);
      chk("ori_rt", {27'b0, dif.rt}, 32'd8);
      chk("ori_imm16", {16'b0, dif.imm16}, 32'h1234);
      tick();

      // back-to-back addu then jr
      dif.instr_in = 32'h0109_5021;
      dif.in_valid = 1'b1;
      tick();
      chk("b2b_addu", {21'b0, dut_cls}, {21'b0, CAddu});
      chk("b2b_rd", {27'b0, dif.rd}, 32'd10);
      chk("b2b_ready0", {31'b0, dif.in_ready}, 32'h1);
      dif.instr_in = 32'h03E0_0008;
      tick();
      chk("b2b_jr", {21'b0, dut_cls}, {21'b0, CJr});
      chk("b2b_rs", {27'b0, dif.rs}, 32'd31);
      chk("b2b_ready1", {31'b0, dif.in_ready}, 32'h1);
      dif.in_valid = 1'b0;
      tick();
      chk("b2b_drained", {31'b0, dif.out_valid}, 32'h0);

      // lw held under back-pressure, then consume and capture in the same cycle
      dif.out_ready = 1'b0;
      dif.instr_in  = 32'h8C00_0004;
      dif.in_valid  = 1'b1;
      tick();
      dif.instr_in = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", {31'b0, dif.in_ready}, 32'h0);
         chk("stall_instr", dif.instr_out, 32'h8C00_0004);
         chk("stall_class", {21'b0, dut_cls}, {21'b0, CLw});
         chk("stall_imm16", {16'b0, dif.imm16}, 32'h4);
         tick();
      end
      dif.out_ready = 1'b1;
      #1;
      chk("release_in_ready", {31'b0, dif.in_ready}, 32'h1);
      tick();
      chk("release_nop", {21'b0, dut_cls}, {21'b0, CNop});
      chk("release_instr", dif.instr_out, 32'h0);
      dif.instr_in = 32'hFC00_0000;
      tick();
      chk("illegal_class", {21'b0, dut_cls}, {21'b0, CIll});
      dif.in_valid = 1'b0;
      tick();

      // flush wins over hold and capture
      dif.out_ready = 1'b0;
      dif.instr_in  = 32'h3408_1234;
      dif.in_valid  = 1'b1;
      tick();
      chk("pre_flush_valid", {31'b0, dif.out_valid}, 32'h1);
      dif.flush = 1'b1;
      #1;
      chk("flush_in_ready", {31'b0, dif.in_ready}, 32'h0);
      tick();
      chk("flush_valid", {31'b0, dif.out_valid}, 32'h0);
      chk("flush_class", {21'b0, dut_cls}, 32'h0);
      dif.flush = 1'b0;

      // asynchronous reset mid-cycle with an entry held
      dif.instr_in = 32'h0109_5021;
      tick();
      dif.in_valid = 1'b0;
      chk("pre_reset_valid", {31'b0, dif.out_valid}, 32'h1);
      #3 reset = 1'b1;
      #1;
      chk("areset_valid", {31'b0, dif.out_valid}, 32'h0);
      chk("areset_class", {21'b0, dut_cls}, 32'h0);
      chk("areset_instr", dif.instr_out, 32'h0);
      dif.in_valid = 1'b1;
      tick();
      chk("reset_no_capture", {31'b0, dif.out_valid}, 32'h0);
      dif.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("reset_release_ready", {31'b0, dif.in_ready}, 32'h1);

`ifdef DECODE_ILLEGAL_CNT_EN
      chk("cnt_reset", {24'b0, dif.illegal_cnt}, 32'h0);
      dif.out_ready = 1'b1;
      dif.instr_in  = 32'hFC00_0000;
      dif.in_valid  = 1'b1;
      repeat (101) tick();
      chk("cnt_100", {24'b0, dif.illegal_cnt}, 32'd100);
      repeat (199) tick();
      dif.in_valid = 1'b0;
      tick();
      tick();
      chk("cnt_saturated", {24'b0, dif.illegal_cnt}, 32'hFF);
`endif

      repeat (600) begin
         dif.in_valid  = 1'($urandom_range(0, 1));
         dif.out_ready = ($urandom_range(0, 3) != 0);
         dif.flush     = ($urandom_range(0, 15) == 0);
         dif.instr_in  = rand_instr();
         dif.pc_in     = $urandom();
         tick();
      end
      dif.in_valid  = 1'b0;
      dif.flush     = 1'b0;
      dif.out_ready = 1'b1;
      tick();
      tick();
      chk("final_drained", {31'b0, dif.out_valid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
